fetch_pair_queue: RTL and testbench
===================================

Name: fetch_pair_queue

Overview:
- Two-wide instruction buffer between the dual-fetch selector and decode/issue.
- Accepts up to two instruction/PC pairs per cycle, in order, from fetch.
- Presents the oldest two entries to decode; decode reports how many it consumed (0/1/2).
- Decouples fetch-pair alignment from issue width and back-pressures fetch when nearly full.

Parameters:
- DEPTH, 8, number of entries; power of two, >= 4.
- CW, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- flush  in  1  synchronous clear (branch mispredict/exception)
- in_valid_a  in  1  fetch slot A valid
- in_instr_a  in  32  slot A instruction
- in_pc_a  in  32  slot A PC
- in_valid_b  in  1  fetch slot B valid; meaningful only with in_valid_a
- in_instr_b  in  32  slot B instruction
- in_pc_b  in  32  slot B PC
- in_ready  out  1  queue can accept a full pair this cycle
- out_valid_a  out  1  head entry valid
- out_instr_a  out  32  head instruction
- out_pc_a  out  32  head PC
- out_valid_b  out  1  head+1 entry valid and issuable with A
- out_instr_b  out  32  head+1 instruction
- out_pc_b  out  32  head+1 PC
- deq_cnt  in  2  entries consumed by decode this cycle (0..2)
- count  out  CW  current occupancy
- pair_blocked  out  1  head+1 present but withheld by pair check

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clk.
- State:
  - Circular storage of DEPTH {instr, pc} entries.
  - head, tail pointers of log2(DEPTH) bits; wrap modulo DEPTH.
  - Registered count.
- Reset:
  - head=tail=count=0.
  - Storage contents don't-care.
  - All out_valid_* = 0, pair_blocked = 0, in_ready = 1.
- in_ready:
  - in_ready = (DEPTH - count) >= 2, computed from registered count only.
  - Same-cycle dequeue does not raise it.
- Enqueue (posedge, no flush, in_ready & in_valid_a):
  - A is written at tail.
  - If in_valid_b, B is written at tail+1 and tail advances by 2; otherwise tail advances by 1.
  - in_valid_b without in_valid_a is ignored.
  - Any valid input while in_ready = 0 is dropped; fetch is required to stall.
- Outputs (combinational from head):
  - out_*_a from storage[head]; out_valid_a = count >= 1.
  - out_*_b from storage[head+1]; out_valid_b = count >= 2 (gated further by the optional feature).
- Dequeue:
  - At posedge, head advances by the effective deq.
  - effective deq = min(deq_cnt, number of out_valid_* asserted); deq_cnt = 3 is treated as 2 and then clamped.
- Count update: count_next = count + enq_n - deq_eff.
  - Simultaneous enqueue and dequeue are legal in the same cycle.
- Latency:
  - An entry written at edge N is visible on out_* after edge N, i.e. one cycle enqueue-to-issue.
  - No bypass from in_* to out_*.
- Full case: count = DEPTH-1 still gives in_ready = 0, since a pair is always assumed.
- Empty case: out_valid_a = out_valid_b = 0; deq_cnt is ignored.
- Flush:
  - Synchronous: head=tail=count=0 at the next edge.
  - Overrides enqueue and dequeue in the same cycle, so incoming instructions are discarded.
- Reset mid-operation clears state immediately (asynchronous).

Optional Feature:
- Macro: FETCH_PAIR_CHECK_EN.
- With the macro: intra-pair RAW check.
  - dest_a = rd (instr[15:11]) if opcode A == 6'h00.
  - dest_a = rt (instr[20:16]) for opcodes 6'h08-6'h0F and 6'h20-6'h2B.
  - dest_a = 0 otherwise.
  - hazard = dest_a != 0 && (dest_a == B.rs || dest_a == B.rt).
  - When count >= 2 and hazard: out_valid_b = 0, pair_blocked = 1, and the effective deq is clamped to 1.
- Without the macro: no check; pair_blocked tied 0.

Test Plan:
- Reset, then one pair A=0x0000_0020/pc 0x0, B=0x2408_0001/pc 0x4 → next cycle out_valid_a = out_valid_b = 1 with those values; count = 2.
- Eight single-A enqueues with deq_cnt = 0 → in_ready = 1 at count 6, in_ready = 0 at count 7; a further pair is dropped and count stays 7.
- count = 3, enqueue pair plus deq_cnt = 2 in the same cycle → count = 3; head advances 2; tail wraps correctly across index 7→0.
- count = 1, deq_cnt = 2 → only 1 removed; count = 0; outputs invalid.
- flush asserted with in_valid_a = 1 and count = 5 → count = 0 next cycle; no entry retained.
- With FETCH_PAIR_CHECK_EN: A = addu $8,$1,$2 (0x0022_4021), B = addiu $9,$8,1 (0x2509_0001) → out_valid_b = 0, pair_blocked = 1; deq_cnt = 2 removes 1.
  - Without the macro, the same stimulus gives out_valid_b = 1.

Source files
------------

// File: rtl/fetch_pair_queue_if.sv
// fetch_pair_queue_if: fetch-side and decode-side signals of the two-wide
// instruction buffer, bundled so the queue and its neighbours share one port.
//
// Handshake semantics: fetch presents a pair on in_valid_a/in_valid_b. The
// pair is taken at the clock edge only when in_ready is high in that same
// cycle. in_ready depends only on registered occupancy, never on in_valid_*
// or deq_cnt. Fetch must hold its pair while in_ready is low, because
// anything offered then is dropped. On the decode side, out_valid_a and
// out_valid_b qualify the two oldest entries. deq_cnt reports how many of
// them decode consumed this cycle, and it is clamped to the number that are
// valid.
interface fetch_pair_queue_if #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
);
  logic          flush;
  logic          in_valid_a;
  logic [31:0]   in_instr_a;
  logic [31:0]   in_pc_a;
  logic          in_valid_b;
  logic [31:0]   in_instr_b;
  logic [31:0]   in_pc_b;
  logic          in_ready;
  logic          out_valid_a;
  logic [31:0]   out_instr_a;
  logic [31:0]   out_pc_a;
  logic          out_valid_b;
  logic [31:0]   out_instr_b;
  logic [31:0]   out_pc_b;
  logic [1:0]    deq_cnt;
  logic [CW-1:0] count;
  logic          pair_blocked;

  modport master (
    output flush, in_valid_a, in_instr_a, in_pc_a,
           in_valid_b, in_instr_b, in_pc_b, deq_cnt,
    input  in_ready, out_valid_a, out_instr_a, out_pc_a,
           out_valid_b, out_instr_b, out_pc_b, count, pair_blocked
  );

  modport slave (
    input  flush, in_valid_a, in_instr_a, in_pc_a,
           in_valid_b, in_instr_b, in_pc_b, deq_cnt,
    output in_ready, out_valid_a, out_instr_a, out_pc_a,
           out_valid_b, out_instr_b, out_pc_b, count, pair_blocked
  );
endinterface

// File: rtl/fetch_pair_queue.sv
// fetch_pair_queue: two-wide circular instruction buffer between dual fetch
// and decode/issue. Up to two entries are enqueued per cycle, and the oldest
// two are presented to decode, which reports how many it consumed.
// Optional feature macro FETCH_PAIR_CHECK_EN enables an intra-pair RAW check.
// When the check fires, the head+1 entry is withheld so that it issues in a
// later cycle.
module fetch_pair_queue #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input logic               clk,
  input logic               reset,
  fetch_pair_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0]   r_instr [DEPTH];
  logic [31:0]   r_pc    [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic [AW-1:0] w_head_p1;
  logic [AW-1:0] w_tail_p1;
  logic          w_ready;
  logic          w_enq_a;
  logic          w_enq_b;
  logic [1:0]    w_enq_n;
  logic          w_avail_a;
  logic          w_avail_b;
  logic          w_hazard;
  logic [1:0]    w_deq_req;
  logic [1:0]    w_avail_n;
  logic [1:0]    w_deq_eff;

  assign w_head_p1 = r_head + AW'(1);
  assign w_tail_p1 = r_tail + AW'(1);

  // A full pair is always assumed, so one free slot is not enough.
  assign w_ready = (r_count <= CW'(DEPTH - 2));

  // in_valid_b without in_valid_a is ignored; flush discards incoming entries.
  assign w_enq_a = !bus.flush && w_ready && bus.in_valid_a;
  assign w_enq_b = w_enq_a && bus.in_valid_b;
  assign w_enq_n = {1'b0, w_enq_a} + {1'b0, w_enq_b};

`ifdef FETCH_PAIR_CHECK_EN
  logic [31:0] w_ia;
  logic [31:0] w_ib;
  logic [5:0]  w_op_a;
  logic [4:0]  w_dest_a;

  assign w_ia   = r_instr[r_head];
  assign w_ib   = r_instr[w_head_p1];
  assign w_op_a = w_ia[31:26];

  // Destination register written by the head instruction (0 = none).
  always_comb begin
    w_dest_a = 5'd0;
    if (w_op_a == 6'h00)
      w_dest_a = w_ia[15:11];
    else if ((w_op_a >= 6'h08 && w_op_a <= 6'h0F) ||
             (w_op_a >= 6'h20 && w_op_a <= 6'h2B))
      w_dest_a = w_ia[20:16];
  end

  assign w_hazard = (w_dest_a != 5'd0) &&
                    ((w_dest_a == w_ib[25:21]) || (w_dest_a == w_ib[20:16]));
`else
  assign w_hazard = 1'b0;
`endif

  assign w_avail_a = (r_count >= CW'(1));
  assign w_avail_b = (r_count >= CW'(2)) && !w_hazard;

  // deq_cnt = 3 behaves as 2. The result is then clamped to the valid outputs.
  assign w_deq_req = (bus.deq_cnt == 2'd3) ? 2'd2 : bus.deq_cnt;
  assign w_avail_n = {1'b0, w_avail_a} + {1'b0, w_avail_b};
  assign w_deq_eff = (w_deq_req < w_avail_n) ? w_deq_req : w_avail_n;

  assign bus.in_ready     = w_ready;
  assign bus.count        = r_count;
  assign bus.out_valid_a  = w_avail_a;
  assign bus.out_instr_a  = r_instr[r_head];
  assign bus.out_pc_a     = r_pc[r_head];
  assign bus.out_valid_b  = w_avail_b;
  assign bus.out_instr_b  = r_instr[w_head_p1];
  assign bus.out_pc_b     = r_pc[w_head_p1];
  assign bus.pair_blocked = (r_count >= CW'(2)) && w_hazard;

  // Storage write: A at tail, B at tail+1. Contents need no reset.
  always_ff @(posedge clk) begin
    if (w_enq_a) begin
      r_instr[r_tail] <= bus.in_instr_a;
      r_pc[r_tail]    <= bus.in_pc_a;
    end
    if (w_enq_b) begin
      r_instr[w_tail_p1] <= bus.in_instr_b;
      r_pc[w_tail_p1]    <= bus.in_pc_b;
    end
  end

  // Pointer and occupancy update. Flush overrides both enqueue and dequeue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (bus.flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + AW'(w_deq_eff);
      r_tail  <= r_tail + AW'(w_enq_n);
      r_count <= r_count + CW'(w_enq_n) - CW'(w_deq_eff);
    end
  end
endmodule

// File: tb/tb_fetch_pair_queue.sv
// tb_fetch_pair_queue: directed scenarios plus randomized traffic. Results
// are checked against a queue-based reference model of the buffer.
module tb_fetch_pair_queue;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef FETCH_PAIR_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  // Clock and reset.
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_pair_queue_if #(.DEPTH(DEPTH)) bus ();
  fetch_pair_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Reference model: each queue entry is {instr, pc}, oldest first.
  logic [63:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [4:0] m_dest(input logic [31:0] ins);
    logic [5:0] op;
    op = ins[31:26];
    if (op == 6'h00) return ins[15:11];
    if ((op >= 6'h08 && op <= 6'h0F) || (op >= 6'h20 && op <= 6'h2B)) return ins[20:16];
    return 5'd0;
  endfunction

  function automatic bit m_hazard();
    logic [63:0] ea, eb;
    logic [4:0]  d;
    logic [31:0] ib;
    if (!CHK_EN || exp_q.size() < 2) return 1'b0;
    ea = exp_q[0];
    eb = exp_q[1];
    d  = m_dest(ea[63:32]);
    ib = eb[63:32];
    return (d != 5'd0) && (d == ib[25:21] || d == ib[20:16]);
  endfunction

  function automatic bit m_va();    return exp_q.size() >= 1;                   endfunction
  function automatic bit m_vb();    return exp_q.size() >= 2 && !m_hazard();    endfunction
  function automatic bit m_pb();    return exp_q.size() >= 2 && m_hazard();     endfunction
  function automatic bit m_ready(); return (DEPTH - exp_q.size()) >= 2;         endfunction

  // Instruction whose opcode never names a destination, so it never blocks.
  function automatic logic [31:0] safe_instr();
    logic [31:0] r;
    r = $urandom();
    return {6'h3F, r[25:0]};
  endfunction

  // Driver: present one cycle of stimulus and advance the model at the edge.
  task automatic apply(input logic f, input logic va, input logic [31:0] ia,
                       input logic [31:0] pa, input logic vb,
                       input logic [31:0] ib, input logic [31:0] pb,
                       input logic [1:0] d);
    int req, avail, eff;
    bit rdy;
    @(negedge clk);
    bus.flush      = f;
    bus.in_valid_a = va;
    bus.in_instr_a = ia;
    bus.in_pc_a    = pa;
    bus.in_valid_b = vb;
    bus.in_instr_b = ib;
    bus.in_pc_b    = pb;
    bus.deq_cnt    = d;
    @(posedge clk);
    rdy = m_ready();
    if (f) begin
      exp_q.delete();
    end else begin
      req   = (d == 2'd3) ? 2 : int'(d);
      avail = int'(m_va()) + int'(m_vb());
      eff   = (req < avail) ? req : avail;
      repeat (eff) void'(exp_q.pop_front());
      if (rdy && va) begin
        exp_q.push_back({ia, pa});
        if (vb) exp_q.push_back({ib, pb});
      end
    end
    #1;
  endtask

  task automatic idle(input logic [1:0] d);
    apply(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, d);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.flush = 1'b0; bus.in_valid_a = 1'b0; bus.in_instr_a = '0; bus.in_pc_a = '0;
    bus.in_valid_b = 1'b0; bus.in_instr_b = '0; bus.in_pc_b = '0; bus.deq_cnt = 2'd0;
    #12;
    checks++; if (bus.count !== '0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.count); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    checks++; if (bus.out_valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid_a got %b exp 0", bus.out_valid_a); end
    checks++; if (bus.out_valid_b !== 1'b0) begin errors++; $display("FAIL reset_valid_b got %b exp 0", bus.out_valid_b); end
    checks++; if (bus.pair_blocked !== 1'b0) begin errors++; $display("FAIL reset_pair_blocked got %b exp 0", bus.pair_blocked); end
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_pair();
    apply(1'b0, 1'b1, 32'h0000_0020, 32'h0, 1'b1, 32'h2408_0001, 32'h4, 2'd0);
    checks++; if (bus.out_valid_a !== 1'b1) begin errors++; $display("FAIL pair_valid_a got %b exp 1", bus.out_valid_a); end
    checks++; if (bus.out_valid_b !== 1'b1) begin errors++; $display("FAIL pair_valid_b got %b exp 1", bus.out_valid_b); end
    checks++; if (bus.out_instr_a !== 32'h0000_0020) begin errors++; $display("FAIL pair_instr_a got %h exp 00000020", bus.out_instr_a); end
    checks++; if (bus.out_pc_a !== 32'h0) begin errors++; $display("FAIL pair_pc_a got %h exp 0", bus.out_pc_a); end
    checks++; if (bus.out_instr_b !== 32'h2408_0001) begin errors++; $display("FAIL pair_instr_b got %h exp 24080001", bus.out_instr_b); end
    checks++; if (bus.out_pc_b !== 32'h4) begin errors++; $display("FAIL pair_pc_b got %h exp 4", bus.out_pc_b); end
    checks++; if (bus.count !== CW'(2)) begin errors++; $display("FAIL pair_count got %0d exp 2", bus.count); end
    idle(2'd2);
    checks++; if (bus.count !== '0) begin errors++; $display("FAIL pair_drain_count got %0d exp 0", bus.count); end
  endtask

  // Fill with single-A enqueues, then wrap the tail across index 7 -> 0.
  task automatic test_full_and_wrap();
    apply(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 2'd0);
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, 1'b1, safe_instr(), 32'(i * 4), 1'b0, '0, '0, 2'd0);
      checks++; if (bus.count !== CW'(exp_q.size())) begin errors++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, bus.count, exp_q.size()); end
      checks++; if (bus.in_ready !== m_ready()) begin errors++; $display("FAIL fill_in_ready[%0d] got %b exp %b", i, bus.in_ready, m_ready()); end
    end
    checks++; if (bus.count !== CW'(7)) begin errors++; $display("FAIL full_count got %0d exp 7", bus.count); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b exp 0", bus.in_ready); end
    apply(1'b0, 1'b1, safe_instr(), 32'h100, 1'b1, safe_instr(), 32'h104, 2'd0);
    checks++; if (bus.count !== CW'(7)) begin errors++; $display("FAIL full_drop_count got %0d exp 7", bus.count); end
    idle(2'd2);
    idle(2'd3);
    checks++; if (bus.count !== CW'(3)) begin errors++; $display("FAIL wrap_pre_count got %0d exp 3", bus.count); end
    apply(1'b0, 1'b1, safe_instr(), 32'h200, 1'b1, safe_instr(), 32'h204, 2'd2);
    checks++; if (bus.count !== CW'(3)) begin errors++; $display("FAIL wrap_count got %0d exp 3", bus.count); end
    while (exp_q.size() > 0) begin
      logic [63:0] e;
      e = exp_q[0];
      checks++; if ({bus.out_instr_a, bus.out_pc_a} !== e) begin errors++; $display("FAIL wrap_head got %h exp %h", {bus.out_instr_a, bus.out_pc_a}, e); end
      idle(2'd1);
    end
  endtask

  task automatic test_underflow();
    apply(1'b0, 1'b1, safe_instr(), 32'h300, 1'b0, '0, '0, 2'd0);
    checks++; if (bus.count !== CW'(1)) begin errors++; $display("FAIL under_pre_count got %0d exp 1", bus.count); end
    checks++; if (bus.out_valid_b !== 1'b0) begin errors++; $display("FAIL under_valid_b got %b exp 0", bus.out_valid_b); end
    idle(2'd2);
    checks++; if (bus.count !== '0) begin errors++; $display("FAIL under_count got %0d exp 0", bus.count); end
    checks++; if (bus.out_valid_a !== 1'b0) begin errors++; $display("FAIL under_valid_a got %b exp 0", bus.out_valid_a); end
    idle(2'd2);
    checks++; if (bus.count !== '0) begin errors++; $display("FAIL empty_deq_count got %0d exp 0", bus.count); end
  endtask

  task automatic test_flush();
    apply(1'b0, 1'b1, safe_instr(), 32'h400, 1'b1, safe_instr(), 32'h404, 2'd0);
    apply(1'b0, 1'b1, safe_instr(), 32'h408, 1'b1, safe_instr(), 32'h40C, 2'd0);
    apply(1'b0, 1'b1, safe_instr(), 32'h410, 1'b0, '0, '0, 2'd0);
    checks++; if (bus.count !== CW'(5)) begin errors++; $display("FAIL flush_pre_count got %0d exp 5", bus.count); end
    apply(1'b1, 1'b1, safe_instr(), 32'h414, 1'b1, safe_instr(), 32'h418, 2'd2);
    checks++; if (bus.count !== '0) begin errors++; $display("FAIL flush_count got %0d exp 0", bus.count); end
    checks++; if (bus.out_valid_a !== 1'b0) begin errors++; $display("FAIL flush_valid_a got %b exp 0", bus.out_valid_a); end
    idle(2'd0);
    checks++; if (bus.count !== '0) begin errors++; $display("FAIL flush_hold_count got %0d exp 0", bus.count); end
  endtask

  task automatic test_hazard();
    apply(1'b0, 1'b1, 32'h0022_4021, 32'h500, 1'b1, 32'h2509_0001, 32'h504, 2'd0);
    checks++; if (bus.out_valid_a !== 1'b1) begin errors++; $display("FAIL hazard_valid_a got %b exp 1", bus.out_valid_a); end
    checks++; if (bus.out_valid_b !== !CHK_EN) begin errors++; $display("FAIL hazard_valid_b got %b exp %b", bus.out_valid_b, !CHK_EN); end
    checks++; if (bus.pair_blocked !== CHK_EN) begin errors++; $display("FAIL hazard_pair_blocked got %b exp %b", bus.pair_blocked, CHK_EN); end
    idle(2'd2);
    checks++; if (bus.count !== CW'(CHK_EN ? 1 : 0)) begin errors++; $display("FAIL hazard_deq_count got %0d exp %0d", bus.count, CHK_EN ? 1 : 0); end
    apply(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 2'd0);
  endtask

  // Reset asserted between edges must clear state without waiting for clk.
  task automatic test_async_reset();
    apply(1'b0, 1'b1, safe_instr(), 32'h600, 1'b1, safe_instr(), 32'h604, 2'd0);
    @(negedge clk);
    bus.in_valid_a = 1'b0; bus.in_valid_b = 1'b0; bus.deq_cnt = 2'd0;
    #1 reset = 1'b1;
    #1;
    checks++; if (bus.count !== '0) begin errors++; $display("FAIL async_reset_count got %0d exp 0", bus.count); end
    checks++; if (bus.out_valid_a !== 1'b0) begin errors++; $display("FAIL async_reset_valid_a got %b exp 0", bus.out_valid_a); end
    #1 reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins [2];
      logic [63:0] ea, eb;
      for (int k = 0; k < 2; k++) begin
        logic [5:0] op;
        case ($urandom_range(0, 3))
          0: op = 6'h00;
          1: op = 6'h09;
          2: op = 6'h23;
          default: op = 6'h3F;
        endcase
        ins[k] = {op, 3'b0, 2'($urandom_range(0, 3)), 3'b0, 2'($urandom_range(0, 3)),
                  3'b0, 2'($urandom_range(0, 3)), 11'h0};
      end
      apply($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, ins[0], $urandom(),
            $urandom_range(0, 1) == 1, ins[1], $urandom(), 2'($urandom_range(0, 3)));
      checks++; if (bus.count !== CW'(exp_q.size())) begin errors++; $display("FAIL rand_count[%0d] got %0d exp %0d", n, bus.count, exp_q.size()); end
      checks++; if (bus.in_ready !== m_ready()) begin errors++; $display("FAIL rand_in_ready[%0d] got %b exp %b", n, bus.in_ready, m_ready()); end
      checks++; if (bus.out_valid_a !== m_va()) begin errors++; $display("FAIL rand_valid_a[%0d] got %b exp %b", n, bus.out_valid_a, m_va()); end
      checks++; if (bus.out_valid_b !== m_vb()) begin errors++; $display("FAIL rand_valid_b[%0d] got %b exp %b", n, bus.out_valid_b, m_vb()); end
      checks++; if (bus.pair_blocked !== m_pb()) begin errors++; $display("FAIL rand_pair_blocked[%0d] got %b exp %b", n, bus.pair_blocked, m_pb()); end
      if (exp_q.size() >= 1) begin
        ea = exp_q[0];
        checks++; if ({bus.out_instr_a, bus.out_pc_a} !== ea) begin errors++; $display("FAIL rand_head_a[%0d] got %h exp %h", n, {bus.out_instr_a, bus.out_pc_a}, ea); end
      end
      if (exp_q.size() >= 2) begin
        eb = exp_q[1];
        checks++; if ({bus.out_instr_b, bus.out_pc_b} !== eb) begin errors++; $display("FAIL rand_head_b[%0d] got %h exp %h", n, {bus.out_instr_b, bus.out_pc_b}, eb); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_pair();
    test_full_and_wrap();
    test_underflow();
    test_flush();
    test_hazard();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
